// File: rtl/axi_pack.sv
// Shared AXI burst types and constants used by the address-channel blocks.
package axi_pack;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_ID_W   = 4;

    typedef logic [7:0] len_type;
    typedef logic [2:0] size_type;
    typedef logic [1:0] burst_type;

    localparam burst_type BURST_FIXED = 2'd0;
    localparam burst_type BURST_INCR  = 2'd1;
    localparam burst_type BURST_WRAP  = 2'd2;
    localparam burst_type BURST_RSVD  = 2'd3;

    localparam int unsigned BOUNDARY_4K = 4096;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        len_type               idx;
        logic                  last;
        logic [AXI_ID_W-1:0]   id;
        logic                  err;
    } beat_desc_t;

    function automatic logic wrap_len_ok(input len_type len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_beat_addr_calc.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// WRAP addressing is built only when AXI_BURST_WRAP_EN is defined; otherwise WRAP follows INCR.
module axi_beat_addr_calc
    import axi_pack::*;
#(
    parameter int ADDR_W = AXI_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] start_i,
    input  len_type           len_i,
    input  size_type          size_i,
    input  burst_type         burst_i,
    output logic [ADDR_W-1:0] next_addr_o
);

    logic [ADDR_W-1:0] beat_bytes;
    logic [ADDR_W-1:0] incr_addr;

    assign beat_bytes = ADDR_W'(1) << size_i;
    // Align down before stepping so an unaligned first beat lands on the next boundary.
    assign incr_addr  = (addr_i & ~(beat_bytes - ADDR_W'(1))) + beat_bytes;

`ifdef AXI_BURST_WRAP_EN
    logic [ADDR_W-1:0] wrap_bytes;
    logic [ADDR_W-1:0] wrap_lo;
    logic [ADDR_W-1:0] wrap_addr;

    assign wrap_bytes = (ADDR_W'(len_i) + ADDR_W'(1)) << size_i;
    assign wrap_lo    = start_i & ~(wrap_bytes - ADDR_W'(1));
    assign wrap_addr  = wrap_lo + ((addr_i + beat_bytes - wrap_lo) & (wrap_bytes - ADDR_W'(1)));
`else
    logic unused_wrap;
    assign unused_wrap = ^{start_i, len_i};
`endif

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        next_addr_o = addr_i;
        case (burst_i)
            BURST_INCR: next_addr_o = incr_addr;
`ifdef AXI_BURST_WRAP_EN
            BURST_WRAP: next_addr_o = wrap_addr;
`else
            BURST_WRAP: next_addr_o = incr_addr;
`endif
            default:    next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI AW/AR request into per-beat descriptors (addr, idx, last, id, err).
// Optional macro AXI_BURST_WRAP_EN enables WRAP addressing; without it WRAP is flagged and walked as INCR.
module axi_burst_addr_gen
    import axi_pack::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = 32,
    parameter int ID_W   = AXI_ID_W
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  len_type           req_len,
    input  size_type          req_size,
    input  burst_type         req_burst,
    input  logic [ID_W-1:0]   req_id,
    output logic              beat_valid,
    input  logic              beat_ready,
    output logic [ADDR_W-1:0] beat_addr,
    output len_type           beat_idx,
    output logic              beat_last,
    output logic [ID_W-1:0]   beat_id,
    output logic              beat_err,
    output logic              busy
);

    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t            state_q, state_d;
    beat_desc_t        beat_q, beat_d;
    logic [ADDR_W-1:0] start_q, start_d;
    len_type           len_q, len_d;
    size_type          size_q, size_d;
    burst_type         burst_q, burst_d;

    logic              req_fire;
    logic              beat_fire;
    logic              req_err;
    logic [ADDR_W-1:0] next_addr;
    logic [11:0]       ofs_aligned;
    logic [16:0]       span_end;

    assign beat_valid = (state_q == ST_BURST);
    assign busy       = (state_q == ST_BURST);
    assign beat_fire  = beat_valid && beat_ready;
    assign req_ready  = (state_q == ST_IDLE) || (beat_fire && beat_q.last);
    assign req_fire   = req_valid && req_ready;

    assign beat_addr  = beat_q.addr;
    assign beat_idx   = beat_q.idx;
    assign beat_last  = beat_q.last;
    assign beat_id    = beat_q.id;
    assign beat_err   = beat_q.err;

    // A burst crosses 4KB when its aligned page offset plus total bytes runs past the page end.
    always_comb begin
        ofs_aligned = req_addr[11:0] & (12'hFFF << req_size);
        span_end    = 17'(ofs_aligned) + ((17'(req_len) + 17'd1) << req_size);
        req_err     = (req_burst == BURST_RSVD)
                   || (int'(req_size) > MAX_SIZE)
                   || ((req_burst == BURST_INCR) && (span_end > 17'(BOUNDARY_4K)));
`ifdef AXI_BURST_WRAP_EN
        if ((req_burst == BURST_WRAP) && !wrap_len_ok(req_len)) req_err = 1'b1;
`else
        if (req_burst == BURST_WRAP) req_err = 1'b1;
`endif
    end

    axi_beat_addr_calc #(.ADDR_W(ADDR_W)) u_calc (
        .addr_i      (beat_q.addr),
        .start_i     (start_q),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        start_d = start_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;

        case (state_q)
            ST_IDLE:  if (req_fire) state_d = ST_BURST;
            ST_BURST: if (beat_fire && beat_q.last) state_d = req_fire ? ST_BURST : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (req_fire) begin
            beat_d.addr = req_addr;
            beat_d.idx  = '0;
            beat_d.last = (req_len == 8'd0);
            beat_d.id   = req_id;
            beat_d.err  = req_err;
            start_d     = req_addr;
            len_d       = req_len;
            size_d      = req_size;
            burst_d     = req_burst;
        end else if (beat_fire && !beat_q.last) begin
            beat_d.addr = next_addr;
            beat_d.idx  = beat_q.idx + 8'd1;
            beat_d.last = ((beat_q.idx + 8'd1) == len_q);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            start_q <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
            beat_q  <= beat_d;
            start_q <= start_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed self-checking bench for axi_burst_addr_gen; expectations follow AXI_BURST_WRAP_EN when defined.
module tb_axi_burst_addr_gen;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [1:0]  req_burst;
    logic [3:0]  req_id;
    logic        beat_valid;
    logic        beat_ready;
    logic [31:0] beat_addr;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic [3:0]  beat_id;
    logic        beat_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef AXI_BURST_WRAP_EN
    localparam logic [31:0] WRAP_A1  = 32'h00;
    localparam logic [31:0] WRAP_A2  = 32'h04;
    localparam logic [31:0] WRAP_A3  = 32'h08;
    localparam logic        WRAP_ERR = 1'b0;
`else
    localparam logic [31:0] WRAP_A1  = 32'h10;
    localparam logic [31:0] WRAP_A2  = 32'h14;
    localparam logic [31:0] WRAP_A3  = 32'h18;
    localparam logic        WRAP_ERR = 1'b1;
`endif

    axi_burst_addr_gen dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_size   (req_size),
        .req_burst  (req_burst),
        .req_id     (req_id),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .beat_id    (beat_id),
        .beat_err   (beat_err),
        .busy       (busy)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; leaves the request dropped one cycle after acceptance.
    task automatic do_req(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [3:0] id);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        req_size  = s;
        req_burst = b;
        req_id    = id;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge ACLK);
        check("req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge ACLK);
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
        req_len   = 8'hFF;
        req_size  = 3'd7;
        req_burst = 2'd3;
        req_id    = 4'hF;
    endtask

    task automatic take_beat(input string tag, input logic [31:0] a, input bit chk_addr,
                             input logic [7:0] idx, input logic last, input logic err,
                             input logic [3:0] id);
        for (int i = 0; i < 20 && !beat_valid; i++) @(negedge ACLK);
        check({tag, ".valid"}, {31'd0, beat_valid}, 32'd1);
        if (chk_addr) check({tag, ".addr"}, beat_addr, a);
        check({tag, ".idx"},  {24'd0, beat_idx},  {24'd0, idx});
        check({tag, ".last"}, {31'd0, beat_last}, {31'd0, last});
        check({tag, ".err"},  {31'd0, beat_err},  {31'd0, err});
        check({tag, ".id"},   {28'd0, beat_id},   {28'd0, id});
        beat_ready = 1'b1;
        @(negedge ACLK);
        beat_ready = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        check({tag, ".idle_valid"}, {31'd0, beat_valid}, 32'd0);
        check({tag, ".idle_busy"},  {31'd0, busy},       32'd0);
        check({tag, ".idle_ready"}, {31'd0, req_ready},  32'd1);
    endtask

    initial begin
        ARESETn    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        req_size   = '0;
        req_burst  = '0;
        req_id     = '0;
        beat_ready = 1'b0;

        #12;
        check("rst.valid", {31'd0, beat_valid}, 32'd0);
        check("rst.busy",  {31'd0, busy},       32'd0);
        check("rst.addr",  beat_addr,           32'd0);
        check("rst.idx",   {24'd0, beat_idx},   32'd0);
        check("rst.id",    {28'd0, beat_id},    32'd0);
        check("rst.last",  {31'd0, beat_last},  32'd0);
        check("rst.err",   {31'd0, beat_err},   32'd0);
        check("rst.ready", {31'd0, req_ready},  32'd1);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);

        // INCR with an unaligned first beat
        do_req(32'h1002, 8'd3, 3'd2, 2'd1, 4'd3);
        check("incr.latency", {31'd0, beat_valid}, 32'd1);
        take_beat("incr0", 32'h1002, 1'b1, 8'd0, 1'b0, 1'b0, 4'd3);
        take_beat("incr1", 32'h1004, 1'b1, 8'd1, 1'b0, 1'b0, 4'd3);
        take_beat("incr2", 32'h1008, 1'b1, 8'd2, 1'b0, 1'b0, 4'd3);
        take_beat("incr3", 32'h100C, 1'b1, 8'd3, 1'b1, 1'b0, 4'd3);
        idle_check("incr");

        // WRAP len=3 size=2 from 0x0C
        do_req(32'h0C, 8'd3, 3'd2, 2'd2, 4'd5);
        take_beat("wrap0", 32'h0C,  1'b1, 8'd0, 1'b0, WRAP_ERR, 4'd5);
        take_beat("wrap1", WRAP_A1, 1'b1, 8'd1, 1'b0, WRAP_ERR, 4'd5);
        take_beat("wrap2", WRAP_A2, 1'b1, 8'd2, 1'b0, WRAP_ERR, 4'd5);
        take_beat("wrap3", WRAP_A3, 1'b1, 8'd3, 1'b1, WRAP_ERR, 4'd5);
        idle_check("wrap");

        // FIXED with a three-cycle stall on beat 1
        do_req(32'h40, 8'd2, 3'd2, 2'd0, 4'd6);
        take_beat("fix0", 32'h40, 1'b1, 8'd0, 1'b0, 1'b0, 4'd6);
        for (int i = 0; i < 3; i++) begin
            check("fix.stall_valid", {31'd0, beat_valid}, 32'd1);
            check("fix.stall_idx",   {24'd0, beat_idx},   32'd1);
            check("fix.stall_addr",  beat_addr,           32'h40);
            @(negedge ACLK);
        end
        take_beat("fix1", 32'h40, 1'b1, 8'd1, 1'b0, 1'b0, 4'd6);
        take_beat("fix2", 32'h40, 1'b1, 8'd2, 1'b1, 1'b0, 4'd6);
        idle_check("fix");

        // Back-to-back: second request accepted on the first burst's last beat
        do_req(32'h100, 8'd1, 3'd2, 2'd1, 4'd1);
        take_beat("b2b.a0", 32'h100, 1'b1, 8'd0, 1'b0, 1'b0, 4'd1);
        check("b2b.a1_addr", beat_addr, 32'h104);
        check("b2b.a1_last", {31'd0, beat_last}, 32'd1);
        beat_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h200;
        req_len    = 8'd0;
        req_size   = 3'd2;
        req_burst  = 2'd1;
        req_id     = 4'd2;
        #1;
        check("b2b.req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge ACLK);
        req_valid  = 1'b0;
        beat_ready = 1'b0;
        check("b2b.no_bubble", {31'd0, beat_valid}, 32'd1);
        check("b2b.busy",      {31'd0, busy},       32'd1);
        take_beat("b2b.b0", 32'h200, 1'b1, 8'd0, 1'b1, 1'b0, 4'd2);
        idle_check("b2b");

        // Illegal requests: error on every beat, full beat count
        do_req(32'hFF8, 8'd3, 3'd2, 2'd1, 4'd7);
        take_beat("x4k0", 32'hFF8,  1'b1, 8'd0, 1'b0, 1'b1, 4'd7);
        take_beat("x4k1", 32'hFFC,  1'b1, 8'd1, 1'b0, 1'b1, 4'd7);
        take_beat("x4k2", 32'h1000, 1'b1, 8'd2, 1'b0, 1'b1, 4'd7);
        take_beat("x4k3", 32'h1004, 1'b1, 8'd3, 1'b1, 1'b1, 4'd7);
        idle_check("x4k");

        do_req(32'h0, 8'd2, 3'd2, 2'd2, 4'd8);
        take_beat("wlen0", 32'h0, 1'b0, 8'd0, 1'b0, 1'b1, 4'd8);
        take_beat("wlen1", 32'h0, 1'b0, 8'd1, 1'b0, 1'b1, 4'd8);
        take_beat("wlen2", 32'h0, 1'b0, 8'd2, 1'b1, 1'b1, 4'd8);
        idle_check("wlen");

        do_req(32'h0, 8'd1, 3'd3, 2'd1, 4'd10);
        take_beat("sz0", 32'h0, 1'b1, 8'd0, 1'b0, 1'b1, 4'd10);
        take_beat("sz1", 32'h8, 1'b1, 8'd1, 1'b1, 1'b1, 4'd10);
        idle_check("sz");

        do_req(32'h20, 8'd1, 3'd2, 2'd3, 4'd11);
        take_beat("rsv0", 32'h20, 1'b1, 8'd0, 1'b0, 1'b1, 4'd11);
        take_beat("rsv1", 32'h20, 1'b1, 8'd1, 1'b1, 1'b1, 4'd11);
        idle_check("rsv");

        // Reset asserted mid-burst
        do_req(32'h0, 8'd7, 3'd2, 2'd1, 4'd9);
        take_beat("rst0", 32'h0, 1'b1, 8'd0, 1'b0, 1'b0, 4'd9);
        check("rst.b1_valid", {31'd0, beat_valid}, 32'd1);
        check("rst.b1_addr",  beat_addr,           32'h4);
        ARESETn = 1'b0;
        #1;
        check("rst.async_valid", {31'd0, beat_valid}, 32'd0);
        check("rst.async_busy",  {31'd0, busy},       32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_check("rst.after");
            beat_ready = 1'b1;
            @(negedge ACLK);
        end
        beat_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
